// File: rtl/step_rect_plotter.sv
// step_rect_plotter
//   Fills axis-aligned rectangles one pixel per clock for a VGA adapter.
//   Two requesters (0: grid redraw, 1: playhead cursor) share the plotter
//   through a round-robin arbiter. A granted rectangle is walked in
//   row-major order. Pixels that fall off-screen still take a cycle but
//   are not plotted.
//
// Ports
//   CLOCK_50            system clock, rising edge
//   Resetn              asynchronous active-low reset
//   req0/req1           rectangle request, held by the requester until its ack
//   x*/y*/w*/h*/c*      corner, size and fill color of each request
//   ack0/ack1           one-cycle pulse in the first drawing cycle of a grant
//   done0/done1         one-cycle pulse after the last pixel of a grant
//   VGA_X/VGA_Y/VGA_COLOR, plot   registered pixel write to the adapter
//   busy                high whenever the plotter is not idle
module step_rect_plotter #(
  parameter int COLOR_DEPTH = 9,
  parameter int X_MAX       = 640,
  parameter int Y_MAX       = 480
) (
  input  logic                   CLOCK_50,
  input  logic                   Resetn,
  input  logic                   req0,
  input  logic [9:0]             x0,
  input  logic [8:0]             y0,
  input  logic [9:0]             w0,
  input  logic [8:0]             h0,
  input  logic [COLOR_DEPTH-1:0] c0,
  input  logic                   req1,
  input  logic [9:0]             x1,
  input  logic [8:0]             y1,
  input  logic [9:0]             w1,
  input  logic [8:0]             h1,
  input  logic [COLOR_DEPTH-1:0] c1,
  output logic                   ack0,
  output logic                   ack1,
  output logic                   done0,
  output logic                   done1,
  output logic [9:0]             VGA_X,
  output logic [8:0]             VGA_Y,
  output logic [COLOR_DEPTH-1:0] VGA_COLOR,
  output logic                   plot,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  // Screen limits widened by one bit so they compare against the
  // carry-extended pixel sums.
  localparam logic [10:0] X_LIM = 11'(X_MAX);
  localparam logic [9:0]  Y_LIM = 10'(Y_MAX);

  state_t                 state_q, state_d;
  logic                   last_q, last_d;     // requester granted last
  logic                   gnt_q, gnt_d;       // requester being served
  logic [9:0]             rx_q, rx_d;
  logic [8:0]             ry_q, ry_d;
  logic [9:0]             rw_q, rw_d;
  logic [8:0]             rh_q, rh_d;
  logic [COLOR_DEPTH-1:0] rc_q, rc_d;
  logic [9:0]             col_q, col_d;
  logic [8:0]             row_q, row_d;
  logic [9:0]             vx_q, vx_d;
  logic [8:0]             vy_q, vy_d;
  logic [COLOR_DEPTH-1:0] vc_q, vc_d;
  logic                   plot_q, plot_d;
  logic                   ack0_q, ack0_d;
  logic                   ack1_q, ack1_d;
  logic                   done0_q, done0_d;
  logic                   done1_q, done1_d;

  // Arbitration and selected request fields
  logic                   sel;
  logic [9:0]             sel_x;
  logic [8:0]             sel_y;
  logic [9:0]             sel_w;
  logic [8:0]             sel_h;
  logic [COLOR_DEPTH-1:0] sel_c;
  logic                   sel_on;

  always_comb begin
    // On a tie the requester not served last wins; otherwise whoever asks.
    sel    = (req0 && req1) ? ~last_q : req1;
    sel_x  = sel ? x1 : x0;
    sel_y  = sel ? y1 : y0;
    sel_w  = sel ? w1 : w0;
    sel_h  = sel ? h1 : h0;
    sel_c  = sel ? c1 : c0;
    sel_on = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM) &&
             (sel_w != '0) && (sel_h != '0);
  end

  // Next pixel position within the latched rectangle
  logic [9:0]  col_nxt;
  logic [8:0]  row_nxt;
  logic [10:0] px_sum;
  logic [9:0]  py_sum;
  logic        nxt_on;
  logic        last_pix;

  always_comb begin
    col_nxt = col_q + 10'd1;
    row_nxt = row_q;
    if (col_q == rw_q - 10'd1) begin
      col_nxt = '0;
      row_nxt = row_q + 9'd1;
    end
    // Sums keep their carry so a corner near the top of the range is
    // rejected rather than wrapping back onto the screen.
    px_sum   = {1'b0, rx_q} + {1'b0, col_nxt};
    py_sum   = {1'b0, ry_q} + {1'b0, row_nxt};
    nxt_on   = !px_sum[10] && !py_sum[9] && (px_sum < X_LIM) && (py_sum < Y_LIM);
    // Zero-sized rectangles finish after their single blank cycle.
    last_pix = (rw_q == '0) || (rh_q == '0) ||
               ((col_q == rw_q - 10'd1) && (row_q == rh_q - 9'd1));
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rw_d    = rw_q;
    rh_d    = rh_q;
    rc_d    = rc_q;
    col_d   = col_q;
    row_d   = row_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    plot_d  = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = DRAW;
          gnt_d   = sel;
          last_d  = sel;
          rx_d    = sel_x;
          ry_d    = sel_y;
          rw_d    = sel_w;
          rh_d    = sel_h;
          rc_d    = sel_c;
          col_d   = '0;
          row_d   = '0;
          // First pixel is registered at the grant edge so it appears
          // together with the ack.
          vx_d    = sel_x;
          vy_d    = sel_y;
          vc_d    = sel_c;
          plot_d  = sel_on;
          ack0_d  = ~sel;
          ack1_d  = sel;
        end
      end
      DRAW: begin
        if (last_pix) begin
          state_d = DONE;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
        end else begin
          col_d  = col_nxt;
          row_d  = row_nxt;
          vx_d   = px_sum[9:0];
          vy_d   = py_sum[8:0];
          plot_d = nxt_on;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      rw_q    <= '0;
      rh_q    <= '0;
      rc_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      plot_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rw_q    <= rw_d;
      rh_q    <= rh_d;
      rc_q    <= rc_d;
      col_q   <= col_d;
      row_q   <= row_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign VGA_X     = vx_q;
  assign VGA_Y     = vy_q;
  assign VGA_COLOR = vc_q;
  assign plot      = plot_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_step_rect_plotter.sv
module tb_step_rect_plotter;

  localparam int CD    = 9;
  localparam int X_MAX = 640;
  localparam int Y_MAX = 480;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [9:0]    x0 = '0, x1 = '0, w0 = '0, w1 = '0;
  logic [8:0]    y0 = '0, y1 = '0, h0 = '0, h1 = '0;
  logic [CD-1:0] c0 = '0, c1 = '0;
  logic          ack0, ack1, done0, done1, plot, busy;
  logic [9:0]    vga_x;
  logic [8:0]    vga_y;
  logic [CD-1:0] vga_c;

  step_rect_plotter #(.COLOR_DEPTH(CD), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .CLOCK_50(clk), .Resetn(rst_n),
    .req0(req0), .x0(x0), .y0(y0), .w0(w0), .h0(h0), .c0(c0),
    .req1(req1), .x1(x1), .y1(y1), .w1(w1), .h1(h1), .c1(c1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .VGA_X(vga_x), .VGA_Y(vga_y), .VGA_COLOR(vga_c), .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Each accepted rectangle expands into a list of per-cycle expectations:
  // its pixels in row-major order followed by one completion cycle.
  typedef struct {
    bit plot;
    int x, y, c;
    bit a0, a1, d0, d1, busy;
  } exp_t;

  exp_t scratch[$];
  exp_t q[$];
  exp_t cur;
  int   m_last = 1;

  function automatic exp_t idle_e();
    exp_t e;
    e.plot = 0; e.x = 0; e.y = 0; e.c = 0;
    e.a0 = 0; e.a1 = 0; e.d0 = 0; e.d1 = 0; e.busy = 0;
    return e;
  endfunction

  function automatic void build_rect(input int who, input int x, input int y,
                                     input int w, input int h, input int c);
    exp_t e;
    scratch.delete();
    if (w == 0 || h == 0) begin
      e = idle_e();
      e.x = x; e.y = y; e.c = c; e.busy = 1;
      e.a0 = (who == 0); e.a1 = (who == 1);
      scratch.push_back(e);
    end else begin
      for (int r = 0; r < h; r++)
        for (int cc = 0; cc < w; cc++) begin
          e = idle_e();
          e.x = x + cc; e.y = y + r; e.c = c; e.busy = 1;
          e.plot = (x + cc < X_MAX) && (y + r < Y_MAX);
          e.a0 = (r == 0 && cc == 0 && who == 0);
          e.a1 = (r == 0 && cc == 0 && who == 1);
          scratch.push_back(e);
        end
    end
    e = idle_e();
    e.busy = 1; e.d0 = (who == 0); e.d1 = (who == 1);
    scratch.push_back(e);
  endfunction

  initial cur = idle_e();

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      q.delete();
      cur = idle_e();
      m_last = 1;
    end else begin
      if (!cur.busy && (req0 || req1)) begin
        g = (req0 && req1) ? (m_last == 1 ? 0 : 1) : (req1 ? 1 : 0);
        m_last = g;
        if (g == 0) build_rect(0, int'(x0), int'(y0), int'(w0), int'(h0), int'(c0));
        else        build_rect(1, int'(x1), int'(y1), int'(w1), int'(h1), int'(c1));
        foreach (scratch[i]) q.push_back(scratch[i]);
      end
      if (q.size() > 0) cur = q.pop_front();
      else              cur = idle_e();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("plot",  int'(plot),  int'(cur.plot));
    chk("busy",  int'(busy),  int'(cur.busy));
    chk("ack0",  int'(ack0),  int'(cur.a0));
    chk("ack1",  int'(ack1),  int'(cur.a1));
    chk("done0", int'(done0), int'(cur.d0));
    chk("done1", int'(done1), int'(cur.d1));
    if (cur.plot) begin
      chk("vga_x", int'(vga_x), cur.x);
      chk("vga_y", int'(vga_y), cur.y);
      chk("vga_c", int'(vga_c), cur.c);
    end
  end

  // ---------------- monitor ----------------
  int px_q[$];
  int py_q[$];
  int ack_order[$];
  int draw_cycles = 0;
  int d0_cnt = 0, d1_cnt = 0;

  always @(negedge clk) begin
    if (plot) begin
      px_q.push_back(int'(vga_x));
      py_q.push_back(int'(vga_y));
    end
    if (busy && !done0 && !done1) draw_cycles++;
    if (ack0) ack_order.push_back(0);
    if (ack1) ack_order.push_back(1);
    if (done0) d0_cnt++;
    if (done1) d1_cnt++;
  end

  task automatic clear_mon();
    px_q.delete(); py_q.delete(); ack_order.delete();
    draw_cycles = 0; d0_cnt = 0; d1_cnt = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int who, input int x, input int y,
                         input int w, input int h, input int c);
    if (who == 0) begin
      x0 = 10'(x); y0 = 9'(y); w0 = 10'(w); h0 = 9'(h); c0 = CD'(c); req0 = 1'b1;
    end else begin
      x1 = 10'(x); y1 = 9'(y); w1 = 10'(w); h1 = 9'(h); c1 = CD'(c); req1 = 1'b1;
    end
  endtask

  // Drop the request and scramble its fields: the rectangle in progress
  // must not change.
  task automatic release_req(input int who);
    if (who == 0) begin
      req0 = 1'b0; x0 = '0; y0 = '0; w0 = 10'd1; h0 = 9'd1; c0 = '0;
    end else begin
      req1 = 1'b0; x1 = '0; y1 = '0; w1 = 10'd1; h1 = 9'd1; c1 = '0;
    end
  endtask

  task automatic wait_ack(input int who, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if ((who == 0 && ack0) || (who == 1 && ack1)) begin
        release_req(who);
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL ack_timeout: requester %0d got no ack within %0d cycles, expected ack", who, budget);
    release_req(who);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic serve_tie();
    bit g0, g1;
    g0 = 0; g1 = 0;
    clear_mon();
    set_req(0, 100, 50, 2, 2, 1);
    set_req(1, 200, 60, 2, 2, 2);
    for (int i = 0; i < 60 && !(g0 && g1); i++) begin
      @(negedge clk);
      if (ack0) begin release_req(0); g0 = 1; end
      if (ack1) begin release_req(1); g1 = 1; end
    end
    if (!(g0 && g1)) begin
      n_tests++; n_fail++;
      $display("FAIL tie_timeout: acks seen %0d/%0d, expected both", g0, g1);
      release_req(0); release_req(1);
    end
    wait_idle(20);
    chk("tie_ack_count", ack_order.size(), 2);
    if (ack_order.size() == 2) begin
      chk("tie_first",  ack_order[0], 0);
      chk("tie_second", ack_order[1], 1);
    end
    chk("tie_done0", d0_cnt, 1);
    chk("tie_done1", d1_cnt, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int ex1[6];
    int ey1[6];
    int pc;
    ex1 = '{10, 11, 12, 10, 11, 12};
    ey1 = '{20, 20, 20, 21, 21, 21};

    // Pin the model against hand-computed values.
    build_rect(0, 10, 20, 3, 2, 'h1FF);
    chk("model_len", scratch.size(), 7);
    chk("model_p3_x", scratch[3].x, 10);
    chk("model_p3_y", scratch[3].y, 21);
    chk("model_p0_ack", int'(scratch[0].a0), 1);
    chk("model_done", int'(scratch[6].d0), 1);
    build_rect(1, 638, 479, 4, 2, 0);
    pc = 0;
    foreach (scratch[i]) if (scratch[i].plot) pc++;
    chk("model_clip_plots", pc, 2);
    scratch.delete();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_c", int'(vga_c), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests: 0 then 1, and 0 again on the next tie.
    serve_tie();
    serve_tie();

    // Single rectangle
    clear_mon();
    set_req(0, 10, 20, 3, 2, 'h1FF);
    wait_ack(0, 5, n);
    chk("single_ack_latency", n, 1);
    wait_idle(20);
    chk("single_plots", px_q.size(), 6);
    if (px_q.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk("single_px", px_q[i], ex1[i]);
        chk("single_py", py_q[i], ey1[i]);
      end
    chk("single_done0", d0_cnt, 1);
    chk("single_draw_cycles", draw_cycles, 6);

    // Clipping at the bottom-right corner
    clear_mon();
    set_req(1, 638, 479, 4, 2, 'h0AA);
    wait_ack(1, 5, n);
    wait_idle(30);
    chk("clip_draw_cycles", draw_cycles, 8);
    chk("clip_plots", px_q.size(), 2);
    if (px_q.size() == 2) begin
      chk("clip_p0_x", px_q[0], 638);
      chk("clip_p1_x", px_q[1], 639);
      chk("clip_p1_y", py_q[1], 479);
    end
    chk("clip_done1", d1_cnt, 1);

    // Column overflow past 10 bits
    clear_mon();
    set_req(0, 1020, 0, 8, 1, 'h123);
    wait_ack(0, 5, n);
    wait_idle(30);
    chk("ovf_draw_cycles", draw_cycles, 8);
    chk("ovf_plots", px_q.size(), 0);

    // Zero size
    clear_mon();
    set_req(1, 30, 30, 0, 5, 'h010);
    wait_ack(1, 5, n);
    wait_idle(20);
    chk("zero_draw_cycles", draw_cycles, 1);
    chk("zero_plots", px_q.size(), 0);
    chk("zero_done1", d1_cnt, 1);

    // Reset during the 37th pixel of a 10x10 rectangle
    clear_mon();
    set_req(0, 100, 100, 10, 10, 'h077);
    wait_ack(0, 5, n);
    repeat (36) @(negedge clk);
    chk("pre_rst_plot", int'(plot), 1);
    chk("pre_rst_x", int'(vga_x), 106);
    chk("pre_rst_y", int'(vga_y), 103);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_plot", int'(plot), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_vga_y", int'(vga_y), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_done", d0_cnt + d1_cnt, 0);

    // Served normally after reset
    clear_mon();
    set_req(0, 5, 7, 2, 2, 'h055);
    wait_ack(0, 5, n);
    chk("post_rst_ack_latency", n, 1);
    wait_idle(20);
    chk("post_rst_plots", px_q.size(), 4);
    if (px_q.size() == 4) begin
      chk("post_rst_first_x", px_q[0], 5);
      chk("post_rst_first_y", py_q[0], 7);
      chk("post_rst_last_x", px_q[3], 6);
      chk("post_rst_last_y", py_q[3], 8);
    end
    chk("post_rst_done0", d0_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
